// File: rtl/ahb_sram_ctrl.sv
// rtl/ahb_sram_ctrl.sv - AHB-lite slave front end for a 2^AW x 32 single-port SRAM
//
// Ports:
//   clk, rst             bus/SRAM clock, asynchronous active-high reset
//   HSEL, HADDR, HTRANS  AHB-lite address phase (select, byte address, type)
//   HWRITE, HSIZE        AHB-lite address phase (direction, size 0/1/2)
//   HWDATA               AHB-lite data-phase write data
//   HREADY               bus-level ready (end of the current data phase)
//   HREADYOUT, HRESP     slave ready and OKAY/ERROR response
//   HRDATA               read data, taken straight from the SRAM read port
//   sram_addr            SRAM word address (lookahead from HADDR when free)
//   sram_data, sram_wren SRAM write data and write enable
//   sram_q               SRAM registered read data (address of previous edge)
module ahb_sram_ctrl #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_data,
    output logic          sram_wren,
    input  logic [31:0]   sram_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_ADDR_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state;
    logic [AW+1:0] addr_q;
    logic [2:0]    size_q;
    logic          write_q;
    logic          ready_q;
    logic          resp_q;
    logic          wren_q;

    logic accept;
    logic illegal;
    logic port_free;

    assign accept = HSEL & HREADY & HTRANS[1];

    always_comb begin
        illegal = 1'b0;
        if (HADDR[31:AW+2] != '0) begin
            illegal = 1'b1;
        end
        if (HSIZE > 3'd2) begin
            illegal = 1'b1;
        end
        if ((HSIZE == 3'd1) && HADDR[0]) begin
            illegal = 1'b1;
        end
        if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) begin
            illegal = 1'b1;
        end
    end

    // The SRAM port is free for a lookahead read whenever it is neither
    // being written nor re-addressed for a stalled access.
    assign port_free = !wren_q && (state != S_ADDR_WAIT);

    assign sram_addr = port_free ? HADDR[AW+1:2] : addr_q[AW+1:2];
    assign sram_wren = wren_q;
    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;
    assign HRDATA    = sram_q;

    // Sub-word writes merge into the old word, which the SRAM presents on
    // sram_q during the write data phase (it was addressed one edge earlier).
    always_comb begin
        if (size_q == 3'd2) begin
            sram_data = HWDATA;
        end else begin
            sram_data = sram_q;
            if (size_q == 3'd0) begin
                case (addr_q[1:0])
                    2'd0: sram_data[7:0]   = HWDATA[7:0];
                    2'd1: sram_data[15:8]  = HWDATA[15:8];
                    2'd2: sram_data[23:16] = HWDATA[23:16];
                    default: sram_data[31:24] = HWDATA[31:24];
                endcase
            end else if (addr_q[1]) begin
                sram_data[31:16] = HWDATA[31:16];
            end else begin
                sram_data[15:0] = HWDATA[15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
            wren_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
            wren_q  <= 1'b0;
            case (state)
                S_ADDR_WAIT: begin
                    // The stalled access now has its word on sram_q.
                    state  <= write_q ? S_WR : S_RD;
                    wren_q <= write_q;
                end
                S_ERR1: begin
                    state  <= S_ERR2;
                    resp_q <= 1'b1;
                end
                S_IDLE, S_RD, S_WR, S_ERR2: begin
                    if (accept) begin
                        addr_q  <= HADDR[AW+1:0];
                        size_q  <= HSIZE;
                        write_q <= HWRITE;
                    end
                    if (!accept) begin
                        state <= S_IDLE;
                    end else if (illegal) begin
                        state   <= S_ERR1;
                        ready_q <= 1'b0;
                        resp_q  <= 1'b1;
                    end else if (HWRITE && (HSIZE == 3'd2)) begin
                        // Full-word writes never need the old word.
                        state  <= S_WR;
                        wren_q <= 1'b1;
                    end else if (port_free) begin
                        state  <= HWRITE ? S_WR : S_RD;
                        wren_q <= HWRITE;
                    end else begin
                        // A write owns the port this cycle, so the lookahead
                        // read did not happen; re-address in ADDR_WAIT.
                        state   <= S_ADDR_WAIT;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
